// File: rtl/enigma_path_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | enigma_path_sequencer_if                                                 |
// | Character in/out handshake bundle for the rotor path sequencer.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface enigma_path_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] char_in;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] char_out;
    logic       out_err;

    modport master (
        output in_valid, char_in, out_ready,
        input  in_ready, out_valid, char_out, out_err
    );

    modport slave (
        input  in_valid, char_in, out_ready,
        output in_ready, out_valid, char_out, out_err
    );
endinterface
`default_nettype wire

// File: rtl/enigma_path_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | enigma_path_sequencer                                                    |
// | Steps three rotors and walks one letter through a shared lookup unit.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module enigma_path_sequencer (
    input  logic                    clk,
    input  logic                    rst_n,
    enigma_path_sequencer_if.slave  io,
    input  logic                    cfg_load,
    input  logic [4:0]              cfg_pos0,
    input  logic [4:0]              cfg_pos1,
    input  logic [4:0]              cfg_pos2,
    input  logic [4:0]              cfg_notch0,
    input  logic [4:0]              cfg_notch1,
    input  logic [4:0]              cfg_notch2,
    output logic                    cfg_err,
    output logic [4:0]              lu_data,
    output logic [4:0]              lu_position,
    output logic [1:0]              lu_sel,
    output logic                    lu_rev,
    input  logic [4:0]              lu_result,
    output logic [4:0]              pos0,
    output logic [4:0]              pos1,
    output logic [4:0]              pos2
);

    localparam logic [4:0] LAST_LETTER = 5'd25;
    localparam logic [4:0] NOTCH0_RST  = 5'd21;
    localparam logic [4:0] NOTCH1_RST  = 5'd4;
    localparam logic [4:0] NOTCH2_RST  = 5'd16;

    typedef enum logic [3:0] {
        S_IDLE, S_STEP, S_FWD0, S_FWD1, S_FWD2, S_REFL,
        S_REV2, S_REV1, S_REV0, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [2:0][4:0] pos_q, pos_d;
    logic [2:0][4:0] notch_q, notch_d;
    logic [4:0]      work_q, work_d;
    logic [4:0]      char_out_q, char_out_d;
    logic            out_valid_q, out_valid_d;
    logic            out_err_q, out_err_d;
    logic            cfg_err_q, cfg_err_d;
    logic            cfg_ok;
    logic            unused_notch2;

    function automatic logic [4:0] inc26(input logic [4:0] v);
        return (v == LAST_LETTER) ? 5'd0 : v + 5'd1;
    endfunction

    assign cfg_ok = (cfg_pos0 <= LAST_LETTER) && (cfg_pos1 <= LAST_LETTER) &&
                    (cfg_pos2 <= LAST_LETTER) && (cfg_notch0 <= LAST_LETTER) &&
                    (cfg_notch1 <= LAST_LETTER) && (cfg_notch2 <= LAST_LETTER);

    // The slowest rotor has nothing to its left to kick, so its notch is only stored.
    assign unused_notch2 = ^notch_q[2];

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        notch_d     = notch_q;
        work_d      = work_q;
        char_out_d  = char_out_q;
        out_valid_d = out_valid_q;
        out_err_d   = out_err_q;
        cfg_err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_load) begin
                    if (cfg_ok) begin
                        pos_d   = {cfg_pos2, cfg_pos1, cfg_pos0};
                        notch_d = {cfg_notch2, cfg_notch1, cfg_notch0};
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end else if (io.in_valid) begin
                    if (io.char_in <= LAST_LETTER) begin
                        work_d  = io.char_in;
                        state_d = S_STEP;
                    end else begin
                        char_out_d  = io.char_in;
                        out_err_d   = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end
            S_STEP: begin
                // Middle rotor double-steps when it sits on its own notch.
                pos_d[0] = inc26(pos_q[0]);
                if ((pos_q[0] == notch_q[0]) || (pos_q[1] == notch_q[1]))
                    pos_d[1] = inc26(pos_q[1]);
                if (pos_q[1] == notch_q[1])
                    pos_d[2] = inc26(pos_q[2]);
                state_d = S_FWD0;
            end
            S_FWD0: begin work_d = lu_result; state_d = S_FWD1; end
            S_FWD1: begin work_d = lu_result; state_d = S_FWD2; end
            S_FWD2: begin work_d = lu_result; state_d = S_REFL; end
            S_REFL: begin work_d = lu_result; state_d = S_REV2; end
            S_REV2: begin work_d = lu_result; state_d = S_REV1; end
            S_REV1: begin work_d = lu_result; state_d = S_REV0; end
            S_REV0: begin
                work_d      = lu_result;
                char_out_d  = lu_result;
                out_valid_d = 1'b1;
                out_err_d   = 1'b0;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (io.out_ready) begin
                    out_valid_d = 1'b0;
                    out_err_d   = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        lu_sel      = 2'd0;
        lu_rev      = 1'b0;
        lu_position = 5'd0;
        lu_data     = 5'd0;
        case (state_q)
            S_FWD0: begin lu_sel = 2'd0; lu_position = pos_q[0]; lu_data = work_q; end
            S_FWD1: begin lu_sel = 2'd1; lu_position = pos_q[1]; lu_data = work_q; end
            S_FWD2: begin lu_sel = 2'd2; lu_position = pos_q[2]; lu_data = work_q; end
            S_REFL: begin lu_sel = 2'd3; lu_data = work_q; end
            S_REV2: begin lu_sel = 2'd2; lu_rev = 1'b1; lu_position = pos_q[2]; lu_data = work_q; end
            S_REV1: begin lu_sel = 2'd1; lu_rev = 1'b1; lu_position = pos_q[1]; lu_data = work_q; end
            S_REV0: begin lu_sel = 2'd0; lu_rev = 1'b1; lu_position = pos_q[0]; lu_data = work_q; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pos_q       <= '0;
            notch_q     <= {NOTCH2_RST, NOTCH1_RST, NOTCH0_RST};
            work_q      <= 5'd0;
            char_out_q  <= 5'd0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            notch_q     <= notch_d;
            work_q      <= work_d;
            char_out_q  <= char_out_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign io.in_ready  = (state_q == S_IDLE);
    assign io.out_valid = out_valid_q;
    assign io.char_out  = char_out_q;
    assign io.out_err   = out_err_q;
    assign cfg_err      = cfg_err_q;
    assign pos0         = pos_q[0];
    assign pos1         = pos_q[1];
    assign pos2         = pos_q[2];

endmodule
`default_nettype wire

// File: tb/tb_enigma_path_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_enigma_path_sequencer                                                 |
// | Randomised self-checking bench with a behavioural rotor/path model.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_enigma_path_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_load;
    logic [4:0] cfg_pos0, cfg_pos1, cfg_pos2, cfg_notch0, cfg_notch1, cfg_notch2;
    logic       cfg_err;
    logic [4:0] lu_data, lu_position, lu_result;
    logic [1:0] lu_sel;
    logic       lu_rev;
    logic [4:0] pos0, pos1, pos2;
    logic       stub_inc;

    int n_cmp = 0;
    int n_bad = 0;

    int mpos[3];
    int mnotch[3];

    logic [1:0] seq_sel[8];
    logic       seq_rev[8];
    logic [4:0] seq_pos[8];

    always #5 clk = ~clk;

    enigma_path_sequencer_if ifc();

    enigma_path_sequencer dut (
        .clk(clk), .rst_n(rst_n), .io(ifc),
        .cfg_load(cfg_load),
        .cfg_pos0(cfg_pos0), .cfg_pos1(cfg_pos1), .cfg_pos2(cfg_pos2),
        .cfg_notch0(cfg_notch0), .cfg_notch1(cfg_notch1), .cfg_notch2(cfg_notch2),
        .cfg_err(cfg_err),
        .lu_data(lu_data), .lu_position(lu_position), .lu_sel(lu_sel),
        .lu_rev(lu_rev), .lu_result(lu_result),
        .pos0(pos0), .pos1(pos1), .pos2(pos2)
    );

    // Stand-in for the shared rotor/reflector unit.
    function automatic logic [4:0] stub_fn(input logic [4:0] d, input logic [4:0] p,
                                           input logic [1:0] s, input logic r);
        int t;
        t = int'(d) + 3 * int'(p) + 5 * int'(s) + (r ? 11 : 0) + 1;
        return 5'(t % 26);
    endfunction

    always_comb lu_result = stub_inc ? lu_data + 5'd1 : stub_fn(lu_data, lu_position, lu_sel, lu_rev);

    function automatic void model_reset();
        mpos   = '{0, 0, 0};
        mnotch = '{21, 4, 16};
    endfunction

    function automatic void model_cfg(input int p0, p1, p2, n0, n1, n2);
        mpos   = '{p0, p1, p2};
        mnotch = '{n0, n1, n2};
    endfunction

    function automatic void model_step();
        bit kick1, kick2;
        kick1 = (mpos[0] == mnotch[0]) || (mpos[1] == mnotch[1]);
        kick2 = (mpos[1] == mnotch[1]);
        mpos[0] = (mpos[0] + 1) % 26;
        if (kick1) mpos[1] = (mpos[1] + 1) % 26;
        if (kick2) mpos[2] = (mpos[2] + 1) % 26;
    endfunction

    function automatic int model_char(input int c);
        int sels[7];
        int s, p, v;
        sels = '{0, 1, 2, 3, 2, 1, 0};
        v = c;
        for (int i = 0; i < 7; i++) begin
            s = sels[i];
            p = (s == 3) ? 0 : mpos[s];
            if (stub_inc) v = (v + 1) % 32;
            else          v = int'(stub_fn(5'(v), 5'(p), 2'(s), (i >= 4)));
        end
        return v;
    endfunction

    task automatic do_cfg(input logic [4:0] p0, p1, p2, n0, n1, n2);
        cfg_pos0 = p0; cfg_pos1 = p1; cfg_pos2 = p2;
        cfg_notch0 = n0; cfg_notch1 = n1; cfg_notch2 = n2;
        cfg_load = 1'b1;
        @(posedge clk); #1;
        cfg_load = 1'b0;
    endtask

    // Lat counts edges after the accepting edge until out_valid is seen.
    task automatic send_char(input logic [4:0] c, output logic [4:0] ch,
                             output logic er, output int lat);
        int n;
        n = 0;
        ifc.in_valid = 1'b1;
        ifc.char_in  = c;
        while (!ifc.in_ready && n < 40) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        lat = 0;
        seq_sel[0] = lu_sel; seq_rev[0] = lu_rev; seq_pos[0] = lu_position;
        while (!ifc.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat < 8) begin
                seq_sel[lat] = lu_sel; seq_rev[lat] = lu_rev; seq_pos[lat] = lu_position;
            end
        end
        if (!ifc.out_valid) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: out_valid=%0b after %0d edges, required 1", ifc.out_valid, lat);
        end
        ch = ifc.char_out;
        er = ifc.out_err;
        if (ifc.out_ready) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++; if (ifc.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %0b want 0", ifc.out_valid); end
        n_cmp++; if (ifc.out_err !== 1'b0) begin n_bad++; $display("FAIL rst_out_err: got %0b want 0", ifc.out_err); end
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL rst_cfg_err: got %0b want 0", cfg_err); end
        n_cmp++; if (ifc.char_out !== 5'd0) begin n_bad++; $display("FAIL rst_char_out: got %0d want 0", ifc.char_out); end
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        n_cmp++; if (ifc.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %0b want 1", ifc.in_ready); end
        n_cmp++; if ({pos2, pos1, pos0} !== 15'd0) begin n_bad++; $display("FAIL rst_pos: got %0d,%0d,%0d want 0,0,0", pos2, pos1, pos0); end
        n_cmp++; if ({lu_sel, lu_rev, lu_data, lu_position} !== 13'd0) begin n_bad++; $display("FAIL rst_lu_idle: got sel=%0d rev=%0b data=%0d pos=%0d want zeros", lu_sel, lu_rev, lu_data, lu_position); end
    endtask

    task automatic test_basic();
        logic [4:0] ch; logic er; int lat;
        logic [1:0] want_sel[8]; logic want_rev[8]; int want_pos[8];
        stub_inc = 1'b1;
        send_char(5'd4, ch, er, lat);
        model_step();
        want_sel = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};
        want_rev = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        want_pos = '{0, 1, 0, 0, 0, 0, 0, 1};
        n_cmp++; if (lat != 8) begin n_bad++; $display("FAIL basic_latency: got %0d want 8", lat); end
        n_cmp++; if (ch !== 5'd11) begin n_bad++; $display("FAIL basic_char: got %0d want 11", ch); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL basic_err: got %0b want 0", er); end
        n_cmp++; if ({pos2, pos1, pos0} !== {5'd0, 5'd0, 5'd1}) begin n_bad++; $display("FAIL basic_pos: got %0d,%0d,%0d want 0,0,1", pos2, pos1, pos0); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (seq_sel[i] !== want_sel[i] || seq_rev[i] !== want_rev[i] || int'(seq_pos[i]) != want_pos[i]) begin
                n_bad++;
                $display("FAIL basic_lu_seq[%0d]: got sel=%0d rev=%0b pos=%0d want sel=%0d rev=%0b pos=%0d",
                         i, seq_sel[i], seq_rev[i], seq_pos[i], want_sel[i], want_rev[i], want_pos[i]);
            end
        end
        n_cmp++; if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_return_idle: got in_ready=%0b out_valid=%0b want 1,0", ifc.in_ready, ifc.out_valid); end
    endtask

    task automatic test_double_step();
        logic [4:0] ch; logic er; int lat; int exp;
        int want[3][3];
        want = '{'{21, 3, 0}, '{22, 4, 0}, '{23, 5, 1}};
        stub_inc = 1'b0;
        do_cfg(5'd20, 5'd3, 5'd0, 5'd21, 5'd4, 5'd16);
        model_cfg(20, 3, 0, 21, 4, 16);
        for (int i = 0; i < 3; i++) begin
            model_step();
            exp = model_char(7 + i);
            send_char(5'(7 + i), ch, er, lat);
            n_cmp++;
            if (int'(pos0) != want[i][0] || int'(pos1) != want[i][1] || int'(pos2) != want[i][2]) begin
                n_bad++;
                $display("FAIL dstep_pos[%0d]: got %0d,%0d,%0d want %0d,%0d,%0d", i, pos2, pos1, pos0, want[i][2], want[i][1], want[i][0]);
            end
            n_cmp++; if (int'(ch) != exp) begin n_bad++; $display("FAIL dstep_char[%0d]: got %0d want %0d", i, ch, exp); end
        end
    endtask

    task automatic test_wrap();
        logic [4:0] ch; logic er; int lat;
        do_cfg(5'd25, 5'd7, 5'd9, 5'd10, 5'd4, 5'd16);
        model_cfg(25, 7, 9, 10, 4, 16);
        model_step();
        send_char(5'd0, ch, er, lat);
        n_cmp++; if ({pos2, pos1, pos0} !== {5'd9, 5'd7, 5'd0}) begin n_bad++; $display("FAIL wrap_pos: got %0d,%0d,%0d want 9,7,0", pos2, pos1, pos0); end
        n_cmp++; if (int'(ch) != model_char(0)) begin n_bad++; $display("FAIL wrap_char: got %0d want %0d", ch, model_char(0)); end
    endtask

    task automatic test_backpressure();
        logic [4:0] held; int exp; int n;
        model_step();
        exp = model_char(9);
        ifc.out_ready = 1'b0;
        ifc.in_valid  = 1'b1;
        ifc.char_in   = 5'd9;
        @(posedge clk); #1;
        ifc.char_in = 5'd3;
        do_cfg_hold: begin
            cfg_pos0 = 5'd1; cfg_pos1 = 5'd1; cfg_pos2 = 5'd1;
            cfg_notch0 = 5'd1; cfg_notch1 = 5'd30; cfg_notch2 = 5'd1;
            cfg_load = 1'b1;
        end
        n = 0;
        while (!ifc.out_valid && n < 40) begin
            @(posedge clk); #1; n++;
            n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL busy_cfg_err: got %0b want 0", cfg_err); end
        end
        held = ifc.char_out;
        n_cmp++; if (ifc.out_valid !== 1'b1 || int'(held) != exp) begin n_bad++; $display("FAIL bp_char: got valid=%0b char=%0d want 1,%0d", ifc.out_valid, held, exp); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (ifc.char_out !== held || ifc.out_valid !== 1'b1 || ifc.in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: got char=%0d valid=%0b in_ready=%0b want %0d,1,0", i, ifc.char_out, ifc.out_valid, ifc.in_ready, held);
            end
        end
        cfg_load = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1 || ifc.out_err !== 1'b0) begin n_bad++; $display("FAIL bp_release: got valid=%0b in_ready=%0b err=%0b want 0,1,0", ifc.out_valid, ifc.in_ready, ifc.out_err); end
        n_cmp++; if (int'(pos0) != mpos[0] || int'(pos1) != mpos[1] || int'(pos2) != mpos[2]) begin n_bad++; $display("FAIL bp_pos: got %0d,%0d,%0d want %0d,%0d,%0d", pos2, pos1, pos0, mpos[2], mpos[1], mpos[0]); end
    endtask

    task automatic test_errors();
        logic [4:0] ch; logic er; int lat; int exp;
        send_char(5'd27, ch, er, lat);
        n_cmp++; if (ch !== 5'd27 || er !== 1'b1) begin n_bad++; $display("FAIL err_char: got char=%0d err=%0b want 27,1", ch, er); end
        n_cmp++; if (lat != 0) begin n_bad++; $display("FAIL err_latency: got %0d want 0", lat); end
        n_cmp++; if (int'(pos0) != mpos[0] || int'(pos1) != mpos[1] || int'(pos2) != mpos[2]) begin n_bad++; $display("FAIL err_pos: got %0d,%0d,%0d want %0d,%0d,%0d", pos2, pos1, pos0, mpos[2], mpos[1], mpos[0]); end
        do_cfg(5'd1, 5'd2, 5'd3, 5'd4, 5'd30, 5'd5);
        n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL cfg_err_pulse: got %0b want 1", cfg_err); end
        @(posedge clk); #1;
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL cfg_err_width: got %0b want 0", cfg_err); end
        n_cmp++; if (int'(pos0) != mpos[0] || int'(pos1) != mpos[1] || int'(pos2) != mpos[2]) begin n_bad++; $display("FAIL cfg_err_pos: got %0d,%0d,%0d want %0d,%0d,%0d", pos2, pos1, pos0, mpos[2], mpos[1], mpos[0]); end
        model_step();
        exp = model_char(15);
        send_char(5'd15, ch, er, lat);
        n_cmp++; if (int'(ch) != exp || int'(pos1) != mpos[1]) begin n_bad++; $display("FAIL cfg_err_after: got char=%0d pos1=%0d want %0d,%0d", ch, pos1, exp, mpos[1]); end
    endtask

    task automatic test_cfg_priority();
        logic [4:0] ch; logic er; int lat;
        ifc.in_valid = 1'b1;
        ifc.char_in  = 5'd12;
        do_cfg(5'd5, 5'd6, 5'd7, 5'd5, 5'd6, 5'd7);
        model_cfg(5, 6, 7, 5, 6, 7);
        n_cmp++; if (ifc.in_ready !== 1'b1) begin n_bad++; $display("FAIL prio_in_ready: got %0b want 1", ifc.in_ready); end
        n_cmp++; if ({pos2, pos1, pos0} !== {5'd7, 5'd6, 5'd5}) begin n_bad++; $display("FAIL prio_pos_load: got %0d,%0d,%0d want 7,6,5", pos2, pos1, pos0); end
        model_step();
        send_char(5'd12, ch, er, lat);
        n_cmp++; if (lat != 8 || int'(ch) != model_char(12)) begin n_bad++; $display("FAIL prio_char: got lat=%0d char=%0d want 8,%0d", lat, ch, model_char(12)); end
        n_cmp++; if ({pos2, pos1, pos0} !== {5'd8, 5'd7, 5'd6}) begin n_bad++; $display("FAIL prio_pos_step: got %0d,%0d,%0d want 8,7,6", pos2, pos1, pos0); end
    endtask

    task automatic test_random();
        logic [4:0] v[6]; logic [4:0] c, ch; logic er, bad; int lat, exp, exp_lat;
        stub_inc = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bad = 1'b0;
                for (int j = 0; j < 6; j++) begin
                    v[j] = 5'($urandom_range(0, 28));
                    if (v[j] > 5'd25) bad = 1'b1;
                end
                do_cfg(v[0], v[1], v[2], v[3], v[4], v[5]);
                n_cmp++; if (cfg_err !== bad) begin n_bad++; $display("FAIL rnd_cfg_err[%0d]: got %0b want %0b", i, cfg_err, bad); end
                if (!bad) model_cfg(v[0], v[1], v[2], v[3], v[4], v[5]);
            end
            c = 5'($urandom_range(0, 31));
            if (c <= 5'd25) begin
                model_step();
                exp = model_char(int'(c));
                exp_lat = 8;
            end else begin
                exp = int'(c);
                exp_lat = 0;
            end
            send_char(c, ch, er, lat);
            n_cmp++;
            if (int'(ch) != exp || er !== (c > 5'd25) || lat != exp_lat) begin
                n_bad++;
                $display("FAIL rnd_char[%0d]: in=%0d got char=%0d err=%0b lat=%0d want %0d,%0b,%0d", i, c, ch, er, lat, exp, (c > 5'd25), exp_lat);
            end
            n_cmp++;
            if (int'(pos0) != mpos[0] || int'(pos1) != mpos[1] || int'(pos2) != mpos[2]) begin
                n_bad++;
                $display("FAIL rnd_pos[%0d]: got %0d,%0d,%0d want %0d,%0d,%0d", i, pos2, pos1, pos0, mpos[2], mpos[1], mpos[0]);
            end
        end
    endtask

    task automatic test_reset_midop();
        logic [4:0] ch; logic er; int lat; int exp;
        ifc.in_valid = 1'b1;
        ifc.char_in  = 5'd8;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (lu_sel !== 2'd3) begin n_bad++; $display("FAIL midop_in_refl: got sel=%0d want 3", lu_sel); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (ifc.out_valid !== 1'b0 || {pos2, pos1, pos0} !== 15'd0 || ifc.in_ready !== 1'b1) begin n_bad++; $display("FAIL midop_reset: got valid=%0b pos=%0d,%0d,%0d in_ready=%0b want 0,0,0,0,1", ifc.out_valid, pos2, pos1, pos0, ifc.in_ready); end
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        n_cmp++; if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0) begin n_bad++; $display("FAIL midop_release: got in_ready=%0b valid=%0b want 1,0", ifc.in_ready, ifc.out_valid); end
        for (int i = 0; i < 22; i++) begin
            model_step();
            exp = model_char(i);
            send_char(5'(i), ch, er, lat);
            n_cmp++; if (int'(ch) != exp) begin n_bad++; $display("FAIL midop_char[%0d]: got %0d want %0d", i, ch, exp); end
        end
        n_cmp++; if ({pos2, pos1, pos0} !== {5'd0, 5'd1, 5'd22}) begin n_bad++; $display("FAIL midop_default_notch: got %0d,%0d,%0d want 0,1,22", pos2, pos1, pos0); end
    endtask

    initial begin
        stub_inc      = 1'b1;
        cfg_load      = 1'b0;
        cfg_pos0      = 5'd0; cfg_pos1 = 5'd0; cfg_pos2 = 5'd0;
        cfg_notch0    = 5'd0; cfg_notch1 = 5'd0; cfg_notch2 = 5'd0;
        ifc.in_valid  = 1'b0;
        ifc.char_in   = 5'd0;
        ifc.out_ready = 1'b1;
        model_reset();

        test_reset();
        test_basic();
        test_double_step();
        test_wrap();
        test_backpressure();
        test_errors();
        test_cfg_priority();
        test_random();
        test_reset_midop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
